// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit for the MIPS datapath.
// Runs MULTU/MULT/DIVU/DIV at one bit per cycle on operand magnitudes.
// A final FIX cycle applies sign correction and writes the HI/LO registers.
// HI/LO can also be written directly with MTHI/MTLO whenever the unit is idle.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;

  // Datapath registers, loaded when an operation is accepted.
  logic               is_div;
  logic               neg_q;    // product / quotient is negative
  logic               neg_r;    // remainder is negative
  logic               b_zero;   // divide with a zero divisor
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;      // {upper, multiplier} or {rem, quot}

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub, quot_fix, rem_fix;
  logic               no_borrow;

  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // Operand magnitudes, one iteration of each algorithm, and the sign fix-up.
  always_comb begin
    a_mag = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

    // Shift-add: conditionally add into the upper half, then shift right with carry.
    add_hi   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {add_hi, acc[WIDTH-1:1]};

    // Restoring divide: shifted remainder gets the next dividend bit.
    rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    no_borrow = (rem_sh >= {1'b0, opnd});
    rem_sub   = rem_sh[WIDTH-1:0] - opnd;
    div_next  = no_borrow ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                          : {acc[2*WIDTH-2:0], 1'b0};

    // A zero divisor leaves |a| in the remainder, so correcting its sign
    // reproduces the original dividend; only the quotient needs forcing.
    prod_fix = neg_q ? -acc : acc;
    quot_fix = b_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM and architectural HI/LO registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_hi) hi_q <= wr_data;
          if (wr_lo) lo_q <= wr_data;
          if (start) begin
            state <= S_CALC;
            cnt   <= CNT_W'(WIDTH);
            dbz_q <= 1'b0;
          end
        end
        S_CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          state  <= S_IDLE;
          done_q <= 1'b1;
          dbz_q  <= b_zero;
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: load on accept, iterate while calculating.
  // NOTE: these registers are deliberately not reset; they are always
  // loaded on acceptance before anything reads them.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      is_div <= op[1];
      neg_q  <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      neg_r  <= op[0] & op[1] & src_a[WIDTH-1];
      b_zero <= op[1] & (src_b == '0);
      opnd   <= op[1] ? b_mag : a_mag;
      acc    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
    end else if (state == S_CALC) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed testbench for mdu_seq with a 32-bit and an 8-bit instance.
module tb_mdu_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 32-bit instance signals
  logic        s32_start, s32_wr_hi, s32_wr_lo;
  logic [1:0]  s32_op;
  logic [31:0] s32_a, s32_b, s32_wd;
  logic        d32_busy, d32_done, d32_dbz;
  logic [31:0] d32_hi, d32_lo;

  // 8-bit instance signals
  logic        s8_start, s8_wr_hi, s8_wr_lo;
  logic [1:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_wd;
  logic        d8_busy, d8_done, d8_dbz;
  logic [7:0]  d8_hi, d8_lo;

  mdu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(s32_start), .op(s32_op),
    .src_a(s32_a), .src_b(s32_b), .wr_hi(s32_wr_hi), .wr_lo(s32_wr_lo),
    .wr_data(s32_wd), .busy(d32_busy), .done(d32_done),
    .div_by_zero(d32_dbz), .hi(d32_hi), .lo(d32_lo)
  );

  mdu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .op(s8_op),
    .src_a(s8_a), .src_b(s8_b), .wr_hi(s8_wr_hi), .wr_lo(s8_wr_lo),
    .wr_data(s8_wd), .busy(d8_busy), .done(d8_done),
    .div_by_zero(d8_dbz), .hi(d8_hi), .lo(d8_lo)
  );

  // Launch an op on the 32-bit unit and wait for done (bounded).
  // lat = edges from acceptance to done visible; bcnt = cycles busy was high.
  task automatic do_op32(input logic [1:0] op, input logic [31:0] a, b,
                         output int lat, output int bcnt);
    s32_op = op; s32_a = a; s32_b = b; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    lat = 0; bcnt = 0;
    while (!d32_done && lat < 100) begin
      if (d32_busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op8(input logic [1:0] op, input logic [7:0] a, b,
                        output int lat, output int bcnt);
    s8_op = op; s8_a = a; s8_b = b; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    lat = 0; bcnt = 0;
    while (!d8_done && lat < 100) begin
      if (d8_busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (d32_busy !== 1'b0) begin failures++; $display("FAIL reset_busy32: got %b expected 0", d32_busy); end
    checks++; if (d32_done !== 1'b0) begin failures++; $display("FAIL reset_done32: got %b expected 0", d32_done); end
    checks++; if (d32_dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz32: got %b expected 0", d32_dbz); end
    checks++; if (d32_hi !== 32'h0 || d32_lo !== 32'h0) begin failures++; $display("FAIL reset_hilo32: got %h_%h expected 0_0", d32_hi, d32_lo); end
    checks++; if (d8_busy !== 1'b0 || d8_hi !== 8'h0 || d8_lo !== 8'h0) begin failures++; $display("FAIL reset_8: got busy=%b hi=%h lo=%h expected 0/00/00", d8_busy, d8_hi, d8_lo); end
    reset = 1'b0;
  endtask

  task automatic test_multu;
    int lat, bcnt;
    do_op32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    checks++; if (lat !== 33) begin failures++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    checks++; if (bcnt !== 33) begin failures++; $display("FAIL multu_busy_cycles: got %0d expected 33", bcnt); end
    checks++; if (d32_busy !== 1'b0) begin failures++; $display("FAIL multu_busy_with_done: got %b expected 0", d32_busy); end
    checks++; if (d32_hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi: got %h expected fffffffe", d32_hi); end
    checks++; if (d32_lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo: got %h expected 00000001", d32_lo); end
    @(posedge clk); #1;
    checks++; if (d32_done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse: got %b expected 0", d32_done); end
  endtask

  task automatic test_signed;
    int lat, bcnt;
    do_op32(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
    checks++; if (d32_hi !== 32'hFFFF_FFFF || d32_lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_neg: got %h_%h expected ffffffff_fffffff1", d32_hi, d32_lo); end
    do_op32(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    checks++; if (d32_lo !== 32'hFFFF_FFFD || d32_hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", d32_hi, d32_lo); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency: got %0d expected 33", lat); end
    do_op32(2'b10, 32'd7, 32'd2, lat, bcnt);
    checks++; if (d32_lo !== 32'd3 || d32_hi !== 32'd1) begin failures++; $display("FAIL divu: got hi=%h lo=%h expected hi=1 lo=3", d32_hi, d32_lo); end
  endtask

  task automatic test_div_edge;
    int lat, bcnt;
    do_op32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    checks++; if (d32_lo !== 32'h8000_0000 || d32_hi !== 32'h0) begin failures++; $display("FAIL div_min_m1: got hi=%h lo=%h expected hi=0 lo=80000000", d32_hi, d32_lo); end
    checks++; if (d32_dbz !== 1'b0) begin failures++; $display("FAIL div_min_m1_flag: got %b expected 0", d32_dbz); end
    do_op32(2'b10, 32'd5, 32'd0, lat, bcnt);
    checks++; if (d32_hi !== 32'd5 || d32_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_zero: got hi=%h lo=%h expected hi=5 lo=ffffffff", d32_hi, d32_lo); end
    checks++; if (d32_dbz !== 1'b1) begin failures++; $display("FAIL divu_zero_flag: got %b expected 1", d32_dbz); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL divu_zero_latency: got %0d expected 33", lat); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (d32_dbz !== 1'b1) begin failures++; $display("FAIL dbz_hold: got %b expected 1", d32_dbz); end
    // Signed divide by zero keeps the original (negative) dividend in hi.
    do_op32(2'b11, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
    checks++; if (d32_hi !== 32'hFFFF_FFFB || d32_lo !== 32'hFFFF_FFFF || d32_dbz !== 1'b1) begin failures++; $display("FAIL div_zero_signed: got hi=%h lo=%h dbz=%b expected fffffffb/ffffffff/1", d32_hi, d32_lo, d32_dbz); end
    // Next accepted start clears the flag.
    s32_op = 2'b10; s32_a = 32'd7; s32_b = 32'd2; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    checks++; if (d32_dbz !== 1'b0) begin failures++; $display("FAIL dbz_clear: got %b expected 0", d32_dbz); end
    lat = 0;
    while (!d32_done && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (d32_lo !== 32'd3 || d32_hi !== 32'd1) begin failures++; $display("FAIL divu_after_clear: got hi=%h lo=%h expected hi=1 lo=3", d32_hi, d32_lo); end
  endtask

  task automatic test_disturb;
    int lat;
    // hi=1, lo=3 from the preceding DIVU; product below is 0x3_00000000.
    s32_op = 2'b00; s32_a = 32'h0001_0000; s32_b = 32'h0003_0000; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    s32_op = 2'b10; s32_a = 32'd9; s32_b = 32'd3; s32_start = 1'b1;
    s32_wr_hi = 1'b1; s32_wd = 32'h1234;
    @(posedge clk); #1;
    s32_start = 1'b0; s32_wr_hi = 1'b0;
    checks++; if (d32_hi !== 32'd1) begin failures++; $display("FAIL wr_hi_while_busy: got %h expected 00000001", d32_hi); end
    lat = 4;
    while (!d32_done && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 33) begin failures++; $display("FAIL disturb_latency: got %0d expected 33", lat); end
    checks++; if (d32_hi !== 32'd3 || d32_lo !== 32'd0) begin failures++; $display("FAIL disturb_result: got %h_%h expected 00000003_00000000", d32_hi, d32_lo); end
    s32_wr_lo = 1'b1; s32_wd = 32'hABCD;
    @(posedge clk); #1;
    s32_wr_lo = 1'b0;
    checks++; if (d32_lo !== 32'hABCD || d32_hi !== 32'd3) begin failures++; $display("FAIL wr_lo_idle: got hi=%h lo=%h expected hi=3 lo=abcd", d32_hi, d32_lo); end
    checks++; if (d32_busy !== 1'b0) begin failures++; $display("FAIL wr_lo_no_start: got busy=%b expected 0", d32_busy); end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt;
    bit saw_done;
    s32_op = 2'b00; s32_a = 32'h1234_5678; s32_b = 32'h9ABC_DEF0; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (d32_busy !== 1'b0 || d32_done !== 1'b0) begin failures++; $display("FAIL reset_mid_ctrl: got busy=%b done=%b expected 0/0", d32_busy, d32_done); end
    checks++; if (d32_hi !== 32'h0 || d32_lo !== 32'h0) begin failures++; $display("FAIL reset_mid_hilo: got %h_%h expected 0_0", d32_hi, d32_lo); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (d32_done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL reset_mid_no_done: got %b expected 0", saw_done); end
    do_op32(2'b00, 32'd6, 32'd7, lat, bcnt);
    checks++; if (lat !== 33 || d32_hi !== 32'd0 || d32_lo !== 32'd42) begin failures++; $display("FAIL after_reset_op: got lat=%0d hi=%h lo=%h expected 33/0/2a", lat, d32_hi, d32_lo); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    do_op8(2'b00, 8'hFF, 8'hFF, lat, bcnt);
    checks++; if (d8_hi !== 8'hFE || d8_lo !== 8'h01) begin failures++; $display("FAIL w8_multu: got %h_%h expected fe_01", d8_hi, d8_lo); end
    checks++; if (lat !== 9 || bcnt !== 9) begin failures++; $display("FAIL w8_latency: got lat=%0d busy=%0d expected 9/9", lat, bcnt); end
    // Start issued in the done cycle.
    do_op8(2'b10, 8'd200, 8'd7, lat, bcnt);
    checks++; if (lat !== 9) begin failures++; $display("FAIL w8_b2b_latency: got %0d expected 9", lat); end
    checks++; if (d8_lo !== 8'h1C || d8_hi !== 8'h04) begin failures++; $display("FAIL w8_divu: got hi=%h lo=%h expected hi=04 lo=1c", d8_hi, d8_lo); end
    do_op8(2'b11, 8'h80, 8'hFF, lat, bcnt);
    checks++; if (d8_lo !== 8'h80 || d8_hi !== 8'h00 || d8_dbz !== 1'b0) begin failures++; $display("FAIL w8_div_min_m1: got hi=%h lo=%h dbz=%b expected 00/80/0", d8_hi, d8_lo, d8_dbz); end
  endtask

  initial begin
    reset = 1'b1;
    s32_start = 1'b0; s32_wr_hi = 1'b0; s32_wr_lo = 1'b0;
    s32_op = 2'b00; s32_a = '0; s32_b = '0; s32_wd = '0;
    s8_start = 1'b0; s8_wr_hi = 1'b0; s8_wr_lo = 1'b0;
    s8_op = 2'b00; s8_a = '0; s8_b = '0; s8_wd = '0;
    test_reset;
    test_multu;
    test_signed;
    test_div_edge;
    test_disturb;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised iterative multiply/divide unit for the MIPS datapath; successor to the single-mode shift-add multiplier.
- Executes MULTU, MULT, DIVU and DIV one bit per cycle with a start/busy/done handshake.
- Holds results in architectural HI/LO registers, which feed MFHI/MFLO.
- Supports direct HI/LO writes (MTHI/MTLO) and divide-by-zero flagging.

Parameters:
- WIDTH, 32: operand width in bits; HI and LO are each WIDTH bits; legal values are 4 or more.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch an operation; sampled only when busy=0.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- src_a  in  WIDTH  multiplicand / dividend (rs).
- src_b  in  WIDTH  multiplier / divisor (rt).
- wr_hi  in  1  MTHI strobe; ignored while busy.
- wr_lo  in  1  MTLO strobe; ignored while busy.
- wr_data  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO are valid in this cycle.
- div_by_zero  out  1  set with done when a DIV/DIVU had src_b=0; holds until next accepted start or reset.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; hi, lo, busy, done and div_by_zero are all 0. Reset overrides everything, including mid-operation: the result is discarded and no done pulse is produced.
- States: IDLE, CALC, FIX.
- IDLE -> CALC at an edge where start=1.
  - Latch op and the operand magnitudes. For signed ops use two's-complement absolute values, treated as WIDTH-bit unsigned, so |MIN| = 2^(WIDTH-1).
  - Latch the result sign flags: product/quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB]. Both flags are 0 for unsigned ops.
  - Counter = WIDTH; busy=1 from the next cycle; div_by_zero cleared.
- CALC, one iteration per edge, counter decrements.
  - Multiply: shift-add on a 2*WIDTH accumulator; if multiplier LSB=1, add the multiplicand into the upper half; then shift right one bit with carry-in.
  - Divide: restoring division; shift {rem,quot} left; trial subtract divisor from rem; on no borrow keep the difference and set the quotient LSB.
  - When the counter reaches 0 at an edge, go to FIX.
- FIX, one edge:
  - Apply sign correction: negate the 2W product, quotient and/or remainder per the latched flags.
  - Write hi/lo: product {hi,lo}; for divide, lo = quotient and hi = remainder.
  - Drive done=1 for the following cycle, busy=0, return to IDLE.
- Latency: start accepted at edge 0; done is high and hi/lo are updated after edge WIDTH+1. busy is high for exactly WIDTH+1 cycles.
- Divide by zero: the datapath runs normally (same latency). Result is lo = all ones and hi = original src_a (not sign-corrected); div_by_zero=1 with done.
- DIV of MIN by -1: lo = MIN, hi = 0, falling out of the magnitude/negate arithmetic; no flag.
- start while busy: ignored entirely; the operation in flight is unaffected.
- start in the done cycle: accepted, since busy=0 then.
- wr_hi/wr_lo:
  - Write on the edge only when busy=0; both may be asserted together.
  - If start and wr_* occur in the same cycle, the write lands now and the operation later overwrites both registers at FIX.
- hi/lo hold their values during CALC. Only FIX, wr_* or reset change them.
- done is never asserted together with busy.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles: done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7 b=2 -> lo=3, hi=1.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. Then DIVU a=5 b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1. Next accepted start clears div_by_zero.
- Mid-op disturbances during an operation:
  - Pulse start with different operands mid-op -> ignored; the original result is delivered.
  - wr_hi=1, wr_data=0x1234 during busy -> hi unchanged.
  - After done, wr_lo with 0xABCD -> lo=0xABCD on the next cycle.
- Reset asserted on cycle 10 of a MULTU -> next cycle busy=0, hi=lo=0; no done pulse ever follows. A new start afterwards completes normally.
- WIDTH=8 instance: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 with done after 9 cycles. Back-to-back start in the done cycle -> second result after another 9 cycles.
